// File: rtl/pipelined_datapath.sv
// -----------------------------------------------------------------------------
// pipelined_datapath
//   Three-stage integer datapath: issue (register read + hazard check),
//   EX (registered operands feeding a combinational ALU) and MW (memory access
//   and register writeback). A valid/ready handshake accepts one instruction
//   per cycle. RAW hazards are resolved by bypassing (FORWARDING = 1, with a
//   load-use stall) or by stalling until the producer has retired
//   (FORWARDING = 0). A pending memory request freezes EX and issue until
//   mem_ack_i arrives.
//
// Parameters
//   REG_ADDR_LENGTH : register address width (2**REG_ADDR_LENGTH registers)
//   DATA_WIDTH      : datapath width
//   FORWARDING      : 1 = bypass + load-use stall, 0 = stall on every RAW hazard
//
// Ports
//   clk_i, rst_n_i              : clock, synchronous active-low reset
//   in_valid_i / in_ready_o     : issue handshake
//   reg_addr1_i/2_i/3_i         : rs1 / rs2 / rd
//   reg_we_i, result_src_i      : rd write enable, writeback select
//   imm_ext_i, pc_next_i        : immediate, next PC
//   alu_control_i, alu_src_i    : ALU operation, operand-2 select (1 = imm)
//   data_mem_we_i, data_mem_byte_op_i : store / byte access
//   mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o : memory request
//   mem_ack_i, mem_rdata_i      : memory completion, load data
//   eq_o, alu_out_o             : EX-stage equality flag and ALU result
//   wb_valid_o                  : instruction retired this cycle
//   a0_o                        : contents of register 10
// -----------------------------------------------------------------------------
module pipelined_datapath #(
    parameter int REG_ADDR_LENGTH = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int FORWARDING      = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [REG_ADDR_LENGTH-1:0] reg_addr1_i,
    input  logic [REG_ADDR_LENGTH-1:0] reg_addr2_i,
    input  logic [REG_ADDR_LENGTH-1:0] reg_addr3_i,
    input  logic                       reg_we_i,
    input  logic [1:0]                 result_src_i,
    input  logic [DATA_WIDTH-1:0]      imm_ext_i,
    input  logic [DATA_WIDTH-1:0]      pc_next_i,
    input  logic [3:0]                 alu_control_i,
    input  logic                       alu_src_i,
    input  logic                       data_mem_we_i,
    input  logic                       data_mem_byte_op_i,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic                       mem_byte_op_o,
    output logic [DATA_WIDTH-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0]      mem_wdata_o,
    input  logic                       mem_ack_i,
    input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
    output logic                       eq_o,
    output logic [DATA_WIDTH-1:0]      alu_out_o,
    output logic                       wb_valid_o,
    output logic [DATA_WIDTH-1:0]      a0_o
);

    localparam int NREGS = 2 ** REG_ADDR_LENGTH;
    localparam int SHW   = $clog2(DATA_WIDTH);
    localparam logic [REG_ADDR_LENGTH-1:0] A0_IDX = REG_ADDR_LENGTH'(10);

    // Writeback select encoding
    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC  = 2'b10;
    localparam logic [1:0] RS_IMM = 2'b11;

    // ALU operation encoding
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // An all-zero stage word is a bubble.
    typedef struct packed {
        logic                       valid;
        logic [DATA_WIDTH-1:0]      rs1;
        logic [DATA_WIDTH-1:0]      rs2;
        logic [DATA_WIDTH-1:0]      imm;
        logic [DATA_WIDTH-1:0]      pc_next;
        logic [REG_ADDR_LENGTH-1:0] rd;
        logic                       we;
        logic [1:0]                 result_src;
        logic [3:0]                 alu_control;
        logic                       alu_src;
        logic                       mem_we;
        logic                       byte_op;
    } ex_stage_t;

    typedef struct packed {
        logic                       valid;
        logic [DATA_WIDTH-1:0]      alu;
        logic [DATA_WIDTH-1:0]      rs2;
        logic [DATA_WIDTH-1:0]      imm;
        logic [DATA_WIDTH-1:0]      pc_next;
        logic [REG_ADDR_LENGTH-1:0] rd;
        logic                       we;
        logic [1:0]                 result_src;
        logic                       mem_we;
        logic                       byte_op;
    } mw_stage_t;

    ex_stage_t             ex_q, ex_d;
    mw_stage_t             mw_q, mw_d;
    logic [DATA_WIDTH-1:0] rf_q [NREGS];

    logic [DATA_WIDTH-1:0]      alu_op2_s, alu_res_s, ex_result_s, wb_data_s;
    logic                       alu_eq_s, mw_mem_s, mw_wait_s, wb_valid_s, wb_en_s;
    logic                       hazard_stall_s, accept_s;
    logic [REG_ADDR_LENGTH-1:0] src_addr_s [2];
    logic [DATA_WIDTH-1:0]      src_rf_s   [2];
    logic [DATA_WIDTH-1:0]      src_val_s  [2];
    logic [1:0]                 src_stall_s, ex_hit_s, mw_hit_s;

    // EX-stage ALU and the value this instruction will eventually write back
    always_comb begin
        alu_op2_s = ex_q.alu_src ? ex_q.imm : ex_q.rs2;
        alu_res_s = '0;
        case (ex_q.alu_control)
            ALU_ADD:  alu_res_s = ex_q.rs1 + alu_op2_s;
            ALU_SUB:  alu_res_s = ex_q.rs1 - alu_op2_s;
            ALU_AND:  alu_res_s = ex_q.rs1 & alu_op2_s;
            ALU_OR:   alu_res_s = ex_q.rs1 | alu_op2_s;
            ALU_XOR:  alu_res_s = ex_q.rs1 ^ alu_op2_s;
            ALU_SLL:  alu_res_s = ex_q.rs1 << alu_op2_s[SHW-1:0];
            ALU_SRL:  alu_res_s = ex_q.rs1 >> alu_op2_s[SHW-1:0];
            ALU_SRA:  alu_res_s = $signed(ex_q.rs1) >>> alu_op2_s[SHW-1:0];
            ALU_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_q.rs1) < $signed(alu_op2_s))};
            ALU_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (ex_q.rs1 < alu_op2_s)};
            default:  alu_res_s = '0;
        endcase
        alu_eq_s = (ex_q.rs1 == alu_op2_s);
        // Bypass value for a dependent instruction: for pc_next/imm producers
        // the ALU result is not what gets written, so select the real one.
        case (ex_q.result_src)
            RS_PC:   ex_result_s = ex_q.pc_next;
            RS_IMM:  ex_result_s = ex_q.imm;
            default: ex_result_s = alu_res_s;
        endcase
    end

    // MW-stage memory handshake and writeback selection
    always_comb begin
        mw_mem_s   = mw_q.valid & ((mw_q.result_src == RS_MEM) | mw_q.mem_we);
        mw_wait_s  = mw_mem_s & ~mem_ack_i;
        wb_valid_s = mw_q.valid & ~mw_wait_s;
        wb_en_s    = wb_valid_s & mw_q.we & (mw_q.rd != '0);
        case (mw_q.result_src)
            RS_ALU:  wb_data_s = mw_q.alu;
            RS_MEM:  wb_data_s = mem_rdata_i;
            RS_PC:   wb_data_s = mw_q.pc_next;
            RS_IMM:  wb_data_s = mw_q.imm;
            default: wb_data_s = mw_q.alu;
        endcase
    end

    // Issue: register read with write-through, hazard detection, operand bypass
    always_comb begin
        src_addr_s[0] = reg_addr1_i;
        src_addr_s[1] = reg_addr2_i;
        src_stall_s   = 2'b00;
        ex_hit_s      = 2'b00;
        mw_hit_s      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            src_val_s[i] = '0;
            if (src_addr_s[i] == '0) begin
                src_rf_s[i] = '0;
            end else if (wb_en_s && (mw_q.rd == src_addr_s[i])) begin
                src_rf_s[i] = wb_data_s;
            end else begin
                src_rf_s[i] = rf_q[src_addr_s[i]];
            end
            ex_hit_s[i] = ex_q.valid & ex_q.we & (ex_q.rd != '0) & (ex_q.rd == src_addr_s[i]);
            mw_hit_s[i] = mw_q.valid & mw_q.we & (mw_q.rd != '0) & (mw_q.rd == src_addr_s[i]);
            if (FORWARDING != 32'sd0) begin
                // The younger producer (EX) wins over MW.
                if (ex_hit_s[i]) begin
                    if (ex_q.result_src == RS_MEM) begin
                        src_stall_s[i] = 1'b1;
                    end else begin
                        src_val_s[i] = ex_result_s;
                    end
                end else if (mw_hit_s[i]) begin
                    if (mw_wait_s) begin
                        src_stall_s[i] = 1'b1;
                    end else begin
                        src_val_s[i] = wb_data_s;
                    end
                end else begin
                    src_val_s[i] = src_rf_s[i];
                end
            end else begin
                if (ex_hit_s[i] || mw_hit_s[i]) begin
                    src_stall_s[i] = 1'b1;
                end else begin
                    src_val_s[i] = src_rf_s[i];
                end
            end
        end
        hazard_stall_s = |src_stall_s;
        in_ready_o     = ~mw_wait_s & ~hazard_stall_s;
        accept_s       = in_valid_i & in_ready_o;
    end

    // Next EX contents: hold behind a waiting MW, else new instruction or bubble
    always_comb begin
        ex_d = '0;
        if (mw_wait_s) begin
            ex_d = ex_q;
        end else if (accept_s) begin
            ex_d.valid       = 1'b1;
            ex_d.rs1         = src_val_s[0];
            ex_d.rs2         = src_val_s[1];
            ex_d.imm         = imm_ext_i;
            ex_d.pc_next     = pc_next_i;
            ex_d.rd          = reg_addr3_i;
            ex_d.we          = reg_we_i;
            ex_d.result_src  = result_src_i;
            ex_d.alu_control = alu_control_i;
            ex_d.alu_src     = alu_src_i;
            ex_d.mem_we      = data_mem_we_i;
            ex_d.byte_op     = data_mem_byte_op_i;
        end else begin
            ex_d = '0;
        end
    end

    // Next MW contents: hold while the memory request is outstanding
    always_comb begin
        mw_d = '0;
        if (mw_wait_s) begin
            mw_d = mw_q;
        end else if (ex_q.valid) begin
            mw_d.valid      = 1'b1;
            mw_d.alu        = alu_res_s;
            mw_d.rs2        = ex_q.rs2;
            mw_d.imm        = ex_q.imm;
            mw_d.pc_next    = ex_q.pc_next;
            mw_d.rd         = ex_q.rd;
            mw_d.we         = ex_q.we;
            mw_d.result_src = ex_q.result_src;
            mw_d.mem_we     = ex_q.mem_we;
            mw_d.byte_op    = ex_q.byte_op;
        end else begin
            mw_d = '0;
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ex_q <= '0;
            mw_q <= '0;
        end else begin
            ex_q <= ex_d;
            mw_q <= mw_d;
        end
    end

    // Register file; register 0 is never written
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en_s) begin
            rf_q[mw_q.rd] <= wb_data_s;
        end
    end

    // Request fields are driven from the MW register and read as zero when idle.
    assign mem_req_o     = mw_mem_s;
    assign mem_we_o      = mw_mem_s & mw_q.mem_we;
    assign mem_byte_op_o = mw_mem_s & mw_q.byte_op;
    assign mem_addr_o    = mw_mem_s ? mw_q.alu : '0;
    assign mem_wdata_o   = mw_mem_s ? mw_q.rs2 : '0;
    assign wb_valid_o    = wb_valid_s;
    assign eq_o          = ex_q.valid & alu_eq_s;
    assign alu_out_o     = ex_q.valid ? alu_res_s : '0;
    assign a0_o          = rf_q[A0_IDX];

endmodule

// File: tb/tb_pipelined_datapath.sv
module tb_pipelined_datapath;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC  = 2'b10;
    localparam logic [1:0] RS_IMM = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sel_nf, f_valid, n_valid;
    logic [4:0]  ra1, ra2, ra3;
    logic        rwe, alusrc, dmwe, dbyte, ack;
    logic [1:0]  rsrc;
    logic [31:0] imm, pcn, rdata;
    logic [3:0]  aluc;

    logic        f_ready, f_req, f_mwe, f_mbyte, f_eq, f_wbv;
    logic [31:0] f_addr, f_wdata, f_alu, f_a0;
    logic        n_ready, n_req, n_mwe, n_mbyte, n_eq, n_wbv;
    logic [31:0] n_addr, n_wdata, n_alu, n_a0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign f_valid = in_valid & ~sel_nf;
    assign n_valid = in_valid & sel_nf;

    pipelined_datapath #(.REG_ADDR_LENGTH(5), .DATA_WIDTH(32), .FORWARDING(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(f_valid), .in_ready_o(f_ready),
        .reg_addr1_i(ra1), .reg_addr2_i(ra2), .reg_addr3_i(ra3), .reg_we_i(rwe),
        .result_src_i(rsrc), .imm_ext_i(imm), .pc_next_i(pcn), .alu_control_i(aluc),
        .alu_src_i(alusrc), .data_mem_we_i(dmwe), .data_mem_byte_op_i(dbyte),
        .mem_req_o(f_req), .mem_we_o(f_mwe), .mem_byte_op_o(f_mbyte),
        .mem_addr_o(f_addr), .mem_wdata_o(f_wdata), .mem_ack_i(ack), .mem_rdata_i(rdata),
        .eq_o(f_eq), .alu_out_o(f_alu), .wb_valid_o(f_wbv), .a0_o(f_a0)
    );

    pipelined_datapath #(.REG_ADDR_LENGTH(5), .DATA_WIDTH(32), .FORWARDING(0)) dut_nf (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(n_valid), .in_ready_o(n_ready),
        .reg_addr1_i(ra1), .reg_addr2_i(ra2), .reg_addr3_i(ra3), .reg_we_i(rwe),
        .result_src_i(rsrc), .imm_ext_i(imm), .pc_next_i(pcn), .alu_control_i(aluc),
        .alu_src_i(alusrc), .data_mem_we_i(dmwe), .data_mem_byte_op_i(dbyte),
        .mem_req_o(n_req), .mem_we_o(n_mwe), .mem_byte_op_o(n_mbyte),
        .mem_addr_o(n_addr), .mem_wdata_o(n_wdata), .mem_ack_i(ack), .mem_rdata_i(rdata),
        .eq_o(n_eq), .alu_out_o(n_alu), .wb_valid_o(n_wbv), .a0_o(n_a0)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
        logic        exp_eq;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic w, input logic [1:0] rs,
                         input logic [31:0] im, input logic [3:0] ac, input logic as,
                         input logic mwe, input logic bop);
        in_valid = v; ra1 = r1; ra2 = r2; ra3 = rd; rwe = w; rsrc = rs;
        imm = im; aluc = ac; alusrc = as; dmwe = mwe; dbyte = bop;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, RS_ALU, 32'h0, OP_ADD, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h00000007, 32'h00000007, OP_ADD,  32'h0000000E, 1'b1};
        vecs[1]  = '{32'h00000005, 32'h00000007, OP_SUB,  32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{32'h0000F0F0, 32'h00000FF0, OP_AND,  32'h000000F0, 1'b0};
        vecs[3]  = '{32'h0000F000, 32'h0000000F, OP_OR,   32'h0000F00F, 1'b0};
        vecs[4]  = '{32'hFF00FF00, 32'h0F0F0F0F, OP_XOR,  32'hF00FF00F, 1'b0};
        vecs[5]  = '{32'h00000001, 32'h00000004, OP_SLL,  32'h00000010, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h0000001F, OP_SRL,  32'h00000001, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000004, OP_SRA,  32'hF8000000, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, OP_SLT,  32'h00000001, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, OP_SLTU, 32'h00000000, 1'b0};
        vecs[10] = '{32'h12345678, 32'h12345678, OP_ADD,  32'h2468ACF0, 1'b1};

        sel_nf = 1'b0; ack = 1'b0; rdata = 32'h0; pcn = 32'h0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", {31'd0, f_ready}, 32'd1);
        chk("rst mem_req", {31'd0, f_req}, 32'd0);
        chk("rst wb_valid", {31'd0, f_wbv}, 32'd0);
        chk("rst mem_addr", f_addr, 32'h0);
        chk("rst mem_wdata", f_wdata, 32'h0);
        chk("rst mem_we", {31'd0, f_mwe}, 32'd0);
        chk("rst mem_byte", {31'd0, f_mbyte}, 32'd0);
        chk("rst eq", {31'd0, f_eq}, 32'd0);
        chk("rst alu_out", f_alu, 32'h0);
        chk("rst a0", f_a0, 32'h0);
        chk("rst nf in_ready", {31'd0, n_ready}, 32'd1);

        // addi x10,x0,5: retires in cycle 2, visible in a0 from cycle 3
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, RS_ALU, 32'd5, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 chk("addi ready", {31'd0, f_ready}, 32'd1);
        @(negedge clk); idle();
        #1 chk("addi c1 wb_valid", {31'd0, f_wbv}, 32'd0);
        chk("addi c1 alu_out", f_alu, 32'd5);
        @(negedge clk);
        #1 chk("addi c2 wb_valid", {31'd0, f_wbv}, 32'd1);
        chk("addi c2 a0", f_a0, 32'd0);
        @(negedge clk);
        #1 chk("addi c3 a0", f_a0, 32'd5);
        chk("addi c3 wb_valid", {31'd0, f_wbv}, 32'd0);

        // addi x1,x0,7 ; add x10,x1,x1 back to back with bypass
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, RS_ALU, 32'd7, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 chk("fwd ready0", {31'd0, f_ready}, 32'd1);
        @(negedge clk); drive(1'b1, 5'd1, 5'd1, 5'd10, 1'b1, RS_ALU, 32'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
        #1 chk("fwd ready1", {31'd0, f_ready}, 32'd1);
        @(negedge clk); idle();
        #1 chk("fwd alu_out", f_alu, 32'd14);
        @(negedge clk);
        @(negedge clk);
        #1 chk("fwd a0", f_a0, 32'd14);

        // ALU table: x5 = a, then x10 = x5 op b issued back to back
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, RS_ALU, vecs[i].a, OP_ADD, 1'b1, 1'b0, 1'b0);
            #1 chk($sformatf("vec%0d ready0", i), {31'd0, f_ready}, 32'd1);
            @(negedge clk); drive(1'b1, 5'd5, 5'd0, 5'd10, 1'b1, RS_ALU, vecs[i].b, vecs[i].op, 1'b1, 1'b0, 1'b0);
            #1 chk($sformatf("vec%0d ready1", i), {31'd0, f_ready}, 32'd1);
            @(negedge clk); idle();
            #1 chk($sformatf("vec%0d alu_out", i), f_alu, vecs[i].exp);
            chk($sformatf("vec%0d eq", i), {31'd0, f_eq}, {31'd0, vecs[i].exp_eq});
            @(negedge clk);
            #1 chk($sformatf("vec%0d wb_valid", i), {31'd0, f_wbv}, 32'd1);
            @(negedge clk);
            #1 chk($sformatf("vec%0d a0", i), f_a0, vecs[i].exp);
        end

        // writes to x0 are dropped and never bypassed
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, RS_ALU, 32'd9, OP_ADD, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, RS_ALU, 32'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
        #1 chk("x0 ready", {31'd0, f_ready}, 32'd1);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);
        #1 chk("x0 a0", f_a0, 32'd0);

        // pc_next writeback
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, RS_PC, 32'h77, OP_ADD, 1'b1, 1'b0, 1'b0);
        pcn = 32'h00001004;
        @(negedge clk); idle(); pcn = 32'h0;
        #1 chk("pc alu_out", f_alu, 32'h77);
        @(negedge clk);
        @(negedge clk);
        #1 chk("pc a0", f_a0, 32'h00001004);

        // bypass from MW with one idle cycle between producer and consumer
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, RS_ALU, 32'h55, OP_ADD, 1'b1, 1'b0, 1'b0);
        @(negedge clk); idle();
        @(negedge clk); drive(1'b1, 5'd3, 5'd0, 5'd10, 1'b1, RS_ALU, 32'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
        #1 chk("mwfwd ready", {31'd0, f_ready}, 32'd1);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);
        #1 chk("mwfwd a0", f_a0, 32'h55);

        // load x1 (ack after 3 wait cycles) then add x10,x1,x0
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, RS_MEM, 32'h100, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 chk("ld ready0", {31'd0, f_ready}, 32'd1);
        @(negedge clk); drive(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, RS_ALU, 32'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
        #1 chk("ld use stall", {31'd0, f_ready}, 32'd0);
        chk("ld c1 req", {31'd0, f_req}, 32'd0);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            #1 chk($sformatf("ld c%0d req", k), {31'd0, f_req}, 32'd1);
            chk($sformatf("ld c%0d addr", k), f_addr, 32'h100);
            chk($sformatf("ld c%0d ready", k), {31'd0, f_ready}, 32'd0);
            chk($sformatf("ld c%0d wb_valid", k), {31'd0, f_wbv}, 32'd0);
        end
        @(negedge clk); ack = 1'b1; rdata = 32'h2A;
        #1 chk("ld ack req", {31'd0, f_req}, 32'd1);
        chk("ld ack addr", f_addr, 32'h100);
        chk("ld ack wb_valid", {31'd0, f_wbv}, 32'd1);
        chk("ld ack ready", {31'd0, f_ready}, 32'd1);
        @(negedge clk); idle(); ack = 1'b0; rdata = 32'h0;
        #1 chk("ld after req", {31'd0, f_req}, 32'd0);
        chk("ld use alu_out", f_alu, 32'h2A);
        @(negedge clk);
        #1 chk("ld use wb_valid", {31'd0, f_wbv}, 32'd1);
        @(negedge clk);
        #1 chk("ld a0", f_a0, 32'h2A);

        // x2 = 0xDEADBEEF (imm writeback), then byte store of x2 to 0x40
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, RS_IMM, 32'hDEADBEEF, OP_ADD, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 5'd0, 5'd2, 5'd10, 1'b0, RS_ALU, 32'h40, OP_ADD, 1'b1, 1'b1, 1'b1);
        #1 chk("st ready", {31'd0, f_ready}, 32'd1);
        @(negedge clk); idle();
        #1 chk("st alu_out", f_alu, 32'h40);
        @(negedge clk); ack = 1'b1;
        #1 chk("st req", {31'd0, f_req}, 32'd1);
        chk("st we", {31'd0, f_mwe}, 32'd1);
        chk("st byte", {31'd0, f_mbyte}, 32'd1);
        chk("st wdata", f_wdata, 32'hDEADBEEF);
        chk("st addr", f_addr, 32'h40);
        chk("st wb_valid", {31'd0, f_wbv}, 32'd1);
        @(negedge clk); ack = 1'b0;
        #1 chk("st after req", {31'd0, f_req}, 32'd0);
        @(negedge clk);
        #1 chk("st no regwrite", f_a0, 32'h2A);

        // reset while a load into x10 is waiting for its ack
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, RS_MEM, 32'h200, OP_ADD, 1'b1, 1'b0, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        #1 chk("rl req", {31'd0, f_req}, 32'd1);
        @(negedge clk); rst_n = 1'b0;
        #1 chk("rl wb_valid0", {31'd0, f_wbv}, 32'd0);
        @(negedge clk);
        #1 chk("rl req dropped", {31'd0, f_req}, 32'd0);
        chk("rl wb_valid1", {31'd0, f_wbv}, 32'd0);
        chk("rl a0", f_a0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rl req after", {31'd0, f_req}, 32'd0);
        chk("rl wb_valid2", {31'd0, f_wbv}, 32'd0);

        // FORWARDING = 0: addi x1,x0,7 ; add x10,x1,x1 stalls two cycles
        sel_nf = 1'b1;
        @(negedge clk); drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, RS_ALU, 32'd7, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 chk("nf ready0", {31'd0, n_ready}, 32'd1);
        @(negedge clk); drive(1'b1, 5'd1, 5'd1, 5'd10, 1'b1, RS_ALU, 32'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
        #1 chk("nf stall1", {31'd0, n_ready}, 32'd0);
        @(negedge clk);
        #1 chk("nf stall2", {31'd0, n_ready}, 32'd0);
        @(negedge clk);
        #1 chk("nf ready3", {31'd0, n_ready}, 32'd1);
        @(negedge clk); idle();
        #1 chk("nf alu_out", n_alu, 32'd14);
        @(negedge clk);
        #1 chk("nf wb_valid", {31'd0, n_wbv}, 32'd1);
        @(negedge clk);
        #1 chk("nf a0", n_a0, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
